// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped full-duplex UART with TX/RX FIFOs, registered bus
// read data and sticky error flags.
// Build option: define UART_FIFO_PARITY_EN to add one even-parity bit per
// character on TX and check it on RX (STATUS bit2 = PARERR).
//
// TX FSM states
//   T_IDLE   | line high, baud counter held at 0, waiting for TX FIFO data
//   T_START  | start bit (line low)
//   T_DATA   | DATA_BITS data bits, LSB first
//   T_PARITY | even-parity bit (parity build only)
//   T_STOP   | stop bit; chains straight to T_START if more data is queued
// RX FSM states
//   R_IDLE   | armed, waiting for a synchronised low
//   R_START  | half-bit delay, then start bit re-check (false start filter)
//   R_DATA   | bit-centred data samples, LSB first
//   R_PARITY | parity sample (parity build only)
//   R_STOP   | stop sample, character stored
//   R_WAIT   | framing error seen, waiting for line high before re-arming

module uart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];

  // pointer advance; callers only assert push/pop when legal
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + (AW+1)'(1);
    if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
  end

  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

module uart_fifo #(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [1:0] addr,
  input  logic       cs,
  input  logic       we,
  output logic       tx,
  input  logic       rx
);
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int CW      = $clog2(BIT_DIV + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA,
`ifdef UART_FIFO_PARITY_EN
    T_PARITY,
`endif
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef UART_FIFO_PARITY_EN
    R_PARITY,
`endif
    R_STOP, R_WAIT
  } rx_state_t;

  logic                 wr_en, rd_en, clr;
  logic                 tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_push_req, rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_line_q, tx_line_d;
`ifdef UART_FIFO_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_meta_q, rx_sync_q;

  logic                 rxovr_q, rxovr_d, frerr_q, frerr_d, parerr_q, parerr_d, txovr_q, txovr_d;
  logic                 frerr_evt, parerr_evt;
  logic [7:0]           status, dbr_q, dbr_d;

  assign wr_en       = cs & we;
  assign rd_en       = cs & ~we;
  assign clr         = wr_en && (addr == 2'd1);
  assign tx_push_req = wr_en && (addr == 2'd0);
  // a pop in the same cycle frees a slot, so full only blocks a lone push
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = rd_en && (addr == 2'd0) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  uart_fifo_buf #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .din_i(dbw[DATA_BITS-1:0]),
    .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_fifo_buf #(.W(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_sh_d),
    .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // TX next-state: loads the shifter on pop and drives the line one edge later
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
`ifdef UART_FIFO_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
`ifdef UART_FIFO_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
          tx_line_d  = 1'b0;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CNT_ONE;
        else begin
          tx_state_d = T_DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_sh_q[0];
          tx_cnt_d   = CNT_FULL;
        end
      end
      T_DATA: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CNT_ONE;
        else begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_FIFO_PARITY_EN
            tx_state_d = T_PARITY;
            tx_line_d  = tx_par_q;
`else
            tx_state_d = T_STOP;
            tx_line_d  = 1'b1;
`endif
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_sh_d   = tx_sh_q >> 1;
            tx_line_d = tx_sh_q[1];
          end
        end
      end
`ifdef UART_FIFO_PARITY_EN
      T_PARITY: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CNT_ONE;
        else begin
          tx_state_d = T_STOP;
          tx_line_d  = 1'b1;
          tx_cnt_d   = CNT_FULL;
        end
      end
`endif
      T_STOP: begin
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CNT_ONE;
        else if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
`ifdef UART_FIFO_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
          tx_line_d  = 1'b0;
          tx_cnt_d   = CNT_FULL;
          tx_state_d = T_START;
        end else begin
          tx_state_d = T_IDLE;
          tx_line_d  = 1'b1;
          tx_cnt_d   = '0;
        end
      end
      default: begin
        tx_state_d = T_IDLE;
        tx_line_d  = 1'b1;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // RX next-state: half-bit start qualification, then bit-centred samples
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    frerr_evt   = 1'b0;
    parerr_evt  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      R_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_ONE;
        else if (!rx_sync_q) begin
          rx_state_d = R_DATA;
          rx_bit_d   = '0;
          rx_cnt_d   = CNT_FULL;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_ONE;
        else begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
          rx_cnt_d = CNT_FULL;
          if (rx_bit_q == LAST_BIT) begin
`ifdef UART_FIFO_PARITY_EN
            rx_state_d = R_PARITY;
`else
            rx_state_d = R_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_FIFO_PARITY_EN
      R_PARITY: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_ONE;
        else begin
          parerr_evt = rx_sync_q ^ (^rx_sh_q);
          rx_state_d = R_STOP;
          rx_cnt_d   = CNT_FULL;
        end
      end
`endif
      R_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_ONE;
        else begin
          rx_push_req = 1'b1;
          rx_cnt_d    = '0;
          if (rx_sync_q) rx_state_d = R_IDLE;
          else begin
            frerr_evt  = 1'b1;
            rx_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = R_IDLE;
      end
      default: begin
        rx_state_d = R_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  assign status = {tx_full, tx_empty && (tx_state_q == T_IDLE), !rx_empty,
                   rxovr_q, frerr_q, parerr_q, txovr_q, 1'b0};

  // sticky flags (an event wins over a same-cycle clear) and bus read data
  always_comb begin
    rxovr_d  = (rxovr_q  & ~clr) | (rx_push_req & ~rx_push);
    frerr_d  = (frerr_q  & ~clr) | frerr_evt;
    parerr_d = (parerr_q & ~clr) | parerr_evt;
    txovr_d  = (txovr_q  & ~clr) | (tx_push_req & ~tx_push);
    dbr_d    = '0;
    if (rd_en) begin
      case (addr)
        2'd0:    if (!rx_empty) dbr_d = 8'(rx_head);
        2'd1:    dbr_d = status;
        default: dbr_d = '0;
      endcase
    end
  end

  // all state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rxovr_q    <= 1'b0;
      frerr_q    <= 1'b0;
      parerr_q   <= 1'b0;
      txovr_q    <= 1'b0;
      dbr_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_line_q  <= tx_line_d;
`ifdef UART_FIFO_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rxovr_q    <= rxovr_d;
      frerr_q    <= frerr_d;
      parerr_q   <= parerr_d;
      txovr_q    <= txovr_d;
      dbr_q      <= dbr_d;
    end
  end

  assign tx  = tx_line_q;
  assign dbr = dbr_q;
endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  localparam int CLK_HZ  = 921600;
  localparam int BAUD    = 115200;
  localparam int BIT_DIV = 8;
`ifdef UART_FIFO_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BIT_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dbr;
  logic [7:0] dbw = '0;
  logic [1:0] addr = '0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic       tx;
  logic       rx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .dbr(dbr), .dbw(dbw), .addr(addr),
    .cs(cs), .we(we), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line decoder: records every frame seen on tx
  logic [7:0] mon_byte[$];
  int         mon_start[$];
  bit         mon_ok[$];

  initial begin : decoder
    logic [7:0] b;
    int         st;
    bit         ok;
    forever begin
      @(posedge clk); #2;
      if (!rst && tx === 1'b0) begin
        st = cyc;
        b  = '0;
        repeat (4) @(posedge clk);
        #2;
        ok = (tx === 1'b0);
        for (int j = 0; j < 8; j++) begin
          repeat (BIT_DIV) @(posedge clk);
          #2;
          b[j] = tx;
        end
`ifdef UART_FIFO_PARITY_EN
        repeat (BIT_DIV) @(posedge clk);
        #2;
        if (tx !== ^b) ok = 1'b0;
`endif
        repeat (BIT_DIV) @(posedge clk);
        #2;
        if (tx !== 1'b1) ok = 1'b0;
        mon_byte.push_back(b);
        mon_start.push_back(st);
        mon_ok.push_back(ok);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; dbw = d;
    tick(1);
    cs = 1'b0; we = 1'b0; addr = '0; dbw = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    tick(1);
    d = dbr;
    cs = 1'b0; addr = '0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic rx_bit(input logic v);
    rx_drv = v;
    tick(BIT_DIV);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v);
    rx_bit(1'b0);
    for (int j = 0; j < 8; j++) rx_bit(b[j]);
`ifdef UART_FIFO_PARITY_EN
    rx_bit(^b);
`endif
    rx_bit(stop_v);
    rx_drv = 1'b1;
  endtask

`ifdef UART_FIFO_PARITY_EN
  task automatic send_rx_oddpar(input logic [7:0] b);
    rx_bit(1'b0);
    for (int j = 0; j < 8; j++) rx_bit(b[j]);
    rx_bit(~(^b));
    rx_bit(1'b1);
    rx_drv = 1'b1;
  endtask
`endif

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_FIFO_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic mon_clear();
    mon_byte.delete();
    mon_start.delete();
    mon_ok.delete();
  endtask

  typedef struct {
    bit         wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] s, rd_v, b;
  logic [7:0] exp_q[$];
  bit         ovr;
  int         n, t;

  initial begin
    vecs[0] = '{1'b0, 2'd1, 8'h00, 8'h40};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 2'd2, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 2'd2, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 2'd3, 8'hA5, 8'h00};
    vecs[6] = '{1'b1, 2'd1, 8'hFF, 8'h00};
    vecs[7] = '{1'b0, 2'd1, 8'h00, 8'h40};
    vecs[8] = '{1'b0, 2'd0, 8'h00, 8'h00};

    // reset state
    @(posedge clk); #1;
    tick(3);
    check("rst_tx", tx, 1'b1);
    check("rst_dbr", dbr, 8'h00);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
      else begin
        bus_read(vecs[i].a, rd_v);
        check($sformatf("vec%0d", i), rd_v, vecs[i].exp);
      end
    end
    tick(1);
    check("dbr_idle_zero", dbr, 8'h00);

    // single TX frame, checked every clock
    mon_clear();
    bus_write(2'd0, 8'h55);
    for (int k = 0; k < FRAME_CLKS; k++) begin
      tick(1);
      check($sformatf("tx55_clk%0d", k), tx, frame_bit(8'h55, k / BIT_DIV));
    end
    tick(1);
    check("tx55_idle_line", tx, 1'b1);
    rd_check("tx55_status", 2'd1, 8'h40);
    check("tx55_mon_cnt", mon_byte.size(), 1);
    if (mon_byte.size() > 0) check("tx55_mon_byte", mon_byte[0], 8'h55);

    // TX burst: 17 accepted, 18th dropped
    mon_clear();
    for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(i));
    rd_check("burst_txfull", 2'd1, 8'h80);
    bus_write(2'd0, 8'hEE);
    rd_check("burst_txovr", 2'd1, 8'h82);
    t = 0;
    while (mon_byte.size() < 17 && t < 17 * FRAME_CLKS + 200) begin
      tick(1);
      t++;
    end
    tick(2 * FRAME_CLKS);
    check("burst_count", mon_byte.size(), 17);
    for (int i = 0; i < 17 && i < mon_byte.size(); i++) begin
      check($sformatf("burst_byte%0d", i), mon_byte[i], 8'(i));
      check($sformatf("burst_frame_ok%0d", i), mon_ok[i], 1'b1);
      if (i > 0) check($sformatf("burst_gap%0d", i), mon_start[i] - mon_start[i-1], FRAME_CLKS);
    end
    rd_check("burst_drained", 2'd1, 8'h42);
    bus_write(2'd1, 8'h00);
    rd_check("burst_cleared", 2'd1, 8'h40);

    // loopback single character
    loop_en = 1'b1;
    bus_write(2'd0, 8'hA3);
    s = '0;
    t = 0;
    while (s[5] !== 1'b1 && t < 3 * FRAME_CLKS) begin
      bus_read(2'd1, s);
      t++;
    end
    check("loop_first_avail", s, 8'h20);
    rd_check("loop_then_idle", 2'd1, 8'h60);
    rd_check("loop_data", 2'd0, 8'hA3);
    rd_check("loop_empty_read", 2'd0, 8'h00);
    rd_check("loop_status_end", 2'd1, 8'h40);
    loop_en = 1'b0;

    // framing error
    send_rx(8'h3C, 1'b0);
    tick(20);
    rd_check("frerr_status", 2'd1, 8'h68);
    rd_check("frerr_data", 2'd0, 8'h3C);
    rd_check("frerr_sticky", 2'd1, 8'h48);
    bus_write(2'd1, 8'h00);
    rd_check("frerr_cleared", 2'd1, 8'h40);

    // one-clock glitch is a false start
    rx_drv = 1'b0;
    tick(1);
    rx_drv = 1'b1;
    tick(40);
    rd_check("glitch_status", 2'd1, 8'h40);
    rd_check("glitch_data", 2'd0, 8'h00);

`ifdef UART_FIFO_PARITY_EN
    send_rx_oddpar(8'h07);
    tick(20);
    rd_check("parerr_status", 2'd1, 8'h64);
    rd_check("parerr_data", 2'd0, 8'h07);
    bus_write(2'd1, 8'h00);
    send_rx(8'h5A, 1'b1);
    tick(20);
    rd_check("par_good_status", 2'd1, 8'h60);
    rd_check("par_good_data", 2'd0, 8'h5A);
`endif

    // RX overrun against a queue model
    exp_q.delete();
    ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      if (exp_q.size() < 16) exp_q.push_back(b);
      else ovr = 1'b1;
    end
    tick(20);
    rd_check("ovr_status", 2'd1, 8'h40 | (exp_q.size() > 0 ? 8'h20 : 8'h00) | (ovr ? 8'h10 : 8'h00));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      bus_read(2'd0, rd_v);
      check($sformatf("ovr_data%0d", i), rd_v, exp_q.pop_front());
    end
    rd_check("ovr_empty", 2'd0, 8'h00);
    bus_write(2'd1, 8'h00);
    rd_check("ovr_cleared", 2'd1, 8'h40);

    // random loopback bursts
    loop_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      mon_clear();
      exp_q.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(2'd0, b);
      end
      tick(n * FRAME_CLKS + 40);
      check($sformatf("rnd%0d_txcount", r), mon_byte.size(), n);
      for (int i = 0; i < n && i < mon_byte.size(); i++)
        check($sformatf("rnd%0d_tx%0d", r, i), mon_byte[i], exp_q[i]);
      for (int i = 0; i < n; i++) begin
        bus_read(2'd0, rd_v);
        check($sformatf("rnd%0d_rx%0d", r, i), rd_v, exp_q[i]);
      end
      rd_check($sformatf("rnd%0d_status", r), 2'd1, 8'h40);
    end
    loop_en = 1'b0;

    // reset in the middle of data bit 3
    bus_write(2'd0, 8'h55);
    tick(1 + 4 * BIT_DIV + 2);
    check("midrst_pre_tx", tx, 1'b0);
    rst = 1'b1;
    tick(1);
    check("midrst_tx", tx, 1'b1);
    check("midrst_dbr", dbr, 8'h00);
    rst = 1'b0;
    rd_check("midrst_status", 2'd1, 8'h40);
    tick(2 * FRAME_CLKS);
    check("midrst_tx_stays_high", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
